// File: rtl/riscv_pkg.sv
// Shared pipeline types for the RV32 core: control bundle, result and forwarding selects.
package riscv_pkg;

  typedef enum logic [1:0] {
    RES_ALU = 2'd0,
    RES_MEM = 2'd1,
    RES_PC4 = 2'd2
  } result_src_t;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_WB  = 2'd1,
    FWD_MEM = 2'd2
  } fwd_sel_t;

  typedef struct packed {
    logic        reg_write;
    result_src_t result_src;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        alu_src;
    logic [2:0]  alu_ctrl;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = ctrl_t'('0);

  // x0 is never a forwarding source; the MEM-stage writer outranks WB
  function automatic fwd_sel_t fwd_pick(input logic [4:0] rs,
                                        input logic [4:0] m_rd, input logic m_reg_write,
                                        input logic [4:0] w_rd, input logic w_reg_write);
    if (m_reg_write && (m_rd != 5'd0) && (m_rd == rs))
      return FWD_MEM;
    else if (w_reg_write && (w_rd != 5'd0) && (w_rd == rs))
      return FWD_WB;
    else
      return FWD_REG;
  endfunction

endpackage

// File: rtl/forward_unit.sv
// EX-stage operand forwarding: picks rs1/rs2 sources and builds ALU operands and store data.
module forward_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [4:0]      e_rs1,
  input  logic [4:0]      e_rs2,
  input  logic [XLEN-1:0] e_rd1,
  input  logic [XLEN-1:0] e_rd2,
  input  logic [XLEN-1:0] e_imm,
  input  logic            e_alu_src,
  input  logic [4:0]      m_rd,
  input  logic            m_reg_write,
  input  logic [XLEN-1:0] m_alu_result,
  input  logic [4:0]      w_rd,
  input  logic            w_reg_write,
  input  logic [XLEN-1:0] w_result,
  output fwd_sel_t        fwd_a,
  output fwd_sel_t        fwd_b,
  output logic [XLEN-1:0] e_src_a,
  output logic [XLEN-1:0] e_src_b,
  output logic [XLEN-1:0] e_write_data
);

  logic [XLEN-1:0] rs2_val;

  always_comb begin
    fwd_a = fwd_pick(e_rs1, m_rd, m_reg_write, w_rd, w_reg_write);
    fwd_b = fwd_pick(e_rs2, m_rd, m_reg_write, w_rd, w_reg_write);

    unique case (fwd_a)
      FWD_MEM: e_src_a = m_alu_result;
      FWD_WB:  e_src_a = w_result;
      default: e_src_a = e_rd1;
    endcase

    unique case (fwd_b)
      FWD_MEM: rs2_val = m_alu_result;
      FWD_WB:  rs2_val = w_result;
      default: rs2_val = e_rd2;
    endcase

    e_write_data = rs2_val;
    e_src_b      = e_alu_src ? e_imm : rs2_val;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall detection, flush bubbling and EX operand forwarding.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            d_valid,
  input  logic [4:0]      d_rs1,
  input  logic [4:0]      d_rs2,
  input  logic [4:0]      d_rd,
  input  logic [XLEN-1:0] d_rd1,
  input  logic [XLEN-1:0] d_rd2,
  input  logic [XLEN-1:0] d_imm,
  input  logic [XLEN-1:0] d_pc,
  input  ctrl_t           d_ctrl,
  input  logic            flush_e,
  input  logic [4:0]      m_rd,
  input  logic            m_reg_write,
  input  logic [XLEN-1:0] m_alu_result,
  input  logic [4:0]      w_rd,
  input  logic            w_reg_write,
  input  logic [XLEN-1:0] w_result,
  output logic            stall_d,
  output logic            e_valid,
  output logic [4:0]      e_rd,
  output ctrl_t           e_ctrl,
  output logic [XLEN-1:0] e_pc,
  output logic [XLEN-1:0] e_imm,
  output logic [XLEN-1:0] e_src_a,
  output logic [XLEN-1:0] e_src_b,
  output logic [XLEN-1:0] e_write_data,
  output fwd_sel_t        fwd_a,
  output fwd_sel_t        fwd_b
);

  logic [4:0]      e_rs1;
  logic [4:0]      e_rs2;
  logic [XLEN-1:0] e_rd1;
  logic [XLEN-1:0] e_rd2;
  logic            load_use;
  logic            bubble;

  // rs2 is matched even when the decode instruction ignores it (I-type), trading
  // an occasional spurious stall for not needing operand-usage decode here
  always_comb begin
    load_use = d_valid && e_valid && (e_ctrl.result_src == RES_MEM) && (e_rd != 5'd0)
               && ((e_rd == d_rs1) || (e_rd == d_rs2));
    stall_d  = load_use && !flush_e;
    bubble   = flush_e || stall_d || !d_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_valid <= 1'b0;
      e_ctrl  <= CTRL_NOP;
      e_rs1   <= '0;
      e_rs2   <= '0;
      e_rd    <= '0;
      e_rd1   <= '0;
      e_rd2   <= '0;
      e_imm   <= '0;
      e_pc    <= '0;
    end else if (bubble) begin
      e_valid <= 1'b0;
      e_ctrl  <= CTRL_NOP;
      e_rs1   <= '0;
      e_rs2   <= '0;
      e_rd    <= '0;
      e_rd1   <= '0;
      e_rd2   <= '0;
      e_imm   <= '0;
      e_pc    <= '0;
    end else begin
      e_valid <= 1'b1;
      e_ctrl  <= d_ctrl;
      e_rs1   <= d_rs1;
      e_rs2   <= d_rs2;
      e_rd    <= d_rd;
      e_rd1   <= d_rd1;
      e_rd2   <= d_rd2;
      e_imm   <= d_imm;
      e_pc    <= d_pc;
    end
  end

  forward_unit #(
    .XLEN(XLEN)
  ) u_forward_unit (
    .e_rs1        (e_rs1),
    .e_rs2        (e_rs2),
    .e_rd1        (e_rd1),
    .e_rd2        (e_rd2),
    .e_imm        (e_imm),
    .e_alu_src    (e_ctrl.alu_src),
    .m_rd         (m_rd),
    .m_reg_write  (m_reg_write),
    .m_alu_result (m_alu_result),
    .w_rd         (w_rd),
    .w_reg_write  (w_reg_write),
    .w_result     (w_result),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .e_src_a      (e_src_a),
    .e_src_b      (e_src_b),
    .e_write_data (e_write_data)
  );

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: scoreboard of predicted EX captures plus per-scenario checks.
module tb_id_ex_stage;
  import riscv_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            d_valid;
  logic [4:0]      d_rs1, d_rs2, d_rd;
  logic [XLEN-1:0] d_rd1, d_rd2, d_imm, d_pc;
  ctrl_t           d_ctrl;
  logic            flush_e;
  logic [4:0]      m_rd, w_rd;
  logic            m_reg_write, w_reg_write;
  logic [XLEN-1:0] m_alu_result, w_result;
  logic            stall_d;
  logic            e_valid;
  logic [4:0]      e_rd;
  ctrl_t           e_ctrl;
  logic [XLEN-1:0] e_pc, e_imm, e_src_a, e_src_b, e_write_data;
  fwd_sel_t        fwd_a, fwd_b;

  id_ex_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .d_valid(d_valid),
    .d_rs1(d_rs1), .d_rs2(d_rs2), .d_rd(d_rd),
    .d_rd1(d_rd1), .d_rd2(d_rd2), .d_imm(d_imm), .d_pc(d_pc), .d_ctrl(d_ctrl),
    .flush_e(flush_e),
    .m_rd(m_rd), .m_reg_write(m_reg_write), .m_alu_result(m_alu_result),
    .w_rd(w_rd), .w_reg_write(w_reg_write), .w_result(w_result),
    .stall_d(stall_d), .e_valid(e_valid), .e_rd(e_rd), .e_ctrl(e_ctrl),
    .e_pc(e_pc), .e_imm(e_imm), .e_src_a(e_src_a), .e_src_b(e_src_b),
    .e_write_data(e_write_data), .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            valid;
    logic [4:0]      rs1, rs2, rd;
    logic [XLEN-1:0] rd1, rd2, imm, pc;
    ctrl_t           ctrl;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t bubble_state();
    exp_t b;
    b.valid = 1'b0; b.rs1 = '0; b.rs2 = '0; b.rd = '0;
    b.rd1 = '0; b.rd2 = '0; b.imm = '0; b.pc = '0; b.ctrl = CTRL_NOP;
    return b;
  endfunction

  function automatic logic model_stall();
    return d_valid && cur.valid && (cur.ctrl.result_src == RES_MEM) && (cur.rd != 5'd0)
           && ((cur.rd == d_rs1) || (cur.rd == d_rs2)) && !flush_e;
  endfunction

  function automatic exp_t model_next();
    exp_t n;
    if (flush_e || model_stall() || !d_valid) return bubble_state();
    n.valid = 1'b1; n.rs1 = d_rs1; n.rs2 = d_rs2; n.rd = d_rd;
    n.rd1 = d_rd1; n.rd2 = d_rd2; n.imm = d_imm; n.pc = d_pc; n.ctrl = d_ctrl;
    return n;
  endfunction

  function automatic fwd_sel_t model_fwd(input logic [4:0] rs);
    if (m_reg_write && m_rd != 5'd0 && m_rd == rs) return FWD_MEM;
    if (w_reg_write && w_rd != 5'd0 && w_rd == rs) return FWD_WB;
    return FWD_REG;
  endfunction

  function automatic logic [XLEN-1:0] model_opnd(input fwd_sel_t s, input logic [XLEN-1:0] rf);
    case (s)
      FWD_MEM: return m_alu_result;
      FWD_WB:  return w_result;
      default: return rf;
    endcase
  endfunction

  function automatic ctrl_t mk_ctrl(input logic rw, input result_src_t rs, input logic mw,
                                    input logic asrc);
    ctrl_t c;
    c = CTRL_NOP;
    c.reg_write = rw; c.result_src = rs; c.mem_write = mw; c.alu_src = asrc;
    c.alu_ctrl = 3'd2;
    return c;
  endfunction

  task automatic set_decode(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input logic [XLEN-1:0] rd1,
                            input logic [XLEN-1:0] rd2, input logic [XLEN-1:0] imm,
                            input logic [XLEN-1:0] pc, input ctrl_t c);
    d_valid = v; d_rs1 = rs1; d_rs2 = rs2; d_rd = rd;
    d_rd1 = rd1; d_rd2 = rd2; d_imm = imm; d_pc = pc; d_ctrl = c;
  endtask

  task automatic idle_inputs();
    set_decode(1'b0, '0, '0, '0, '0, '0, '0, '0, CTRL_NOP);
    flush_e = 1'b0;
    m_rd = '0; m_reg_write = 1'b0; m_alu_result = '0;
    w_rd = '0; w_reg_write = 1'b0; w_result = '0;
  endtask

  // Predict what the next rising edge captures, then step past it
  task automatic tick();
    sb.push_back(model_next());
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      checks++;
      if ({e_valid, e_rd, e_ctrl, e_pc, e_imm} !==
          {mon_e.valid, mon_e.rd, mon_e.ctrl, mon_e.pc, mon_e.imm}) begin
        errors++;
        $display("FAIL capture: got v=%0b rd=%0d ctrl=%h pc=%h imm=%h, expected v=%0b rd=%0d ctrl=%h pc=%h imm=%h",
                 e_valid, e_rd, e_ctrl, e_pc, e_imm,
                 mon_e.valid, mon_e.rd, mon_e.ctrl, mon_e.pc, mon_e.imm);
      end
      cur = mon_e;
    end
  end

  task automatic test_reset();
    idle_inputs();
    cur = bubble_state();
    #1 rst_n = 1'b0;
    set_decode(1'b1, 5'd3, 5'd4, 5'd9, 32'hAAAA_0001, 32'hBBBB_0002, 32'h10, 32'h400,
               mk_ctrl(1'b1, RES_MEM, 1'b0, 1'b1));
    m_rd = 5'd3; m_reg_write = 1'b1; m_alu_result = 32'hDEAD_BEEF;
    @(posedge clk); @(posedge clk); #2;
    checks++;
    if ({e_valid, e_rd, e_ctrl, e_pc, e_imm, stall_d} !== {1'b0, 5'd0, CTRL_NOP, 32'd0, 32'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_regs: got v=%0b rd=%0d ctrl=%h pc=%h imm=%h stall=%0b, expected all zero",
               e_valid, e_rd, e_ctrl, e_pc, e_imm, stall_d);
    end
    checks++;
    if ({fwd_a, fwd_b, e_src_a, e_src_b, e_write_data} !== {FWD_REG, FWD_REG, 96'd0}) begin
      errors++;
      $display("FAIL reset_fwd: got fa=%0d fb=%0d a=%h b=%h wd=%h, expected fa=0 fb=0 a=0 b=0 wd=0",
               fwd_a, fwd_b, e_src_a, e_src_b, e_write_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle_inputs();
    tick();
  endtask

  task automatic test_random_stream();
    for (int unsigned i = 0; i < 16; i++) begin
      @(negedge clk);
      set_decode($urandom_range(0, 3) != 0, 5'($urandom_range(0, 6)), 5'($urandom_range(0, 6)),
                 5'($urandom_range(0, 6)), $urandom, $urandom, $urandom, $urandom,
                 mk_ctrl(1'($urandom), result_src_t'($urandom_range(0, 2)), 1'($urandom),
                         1'($urandom)));
      m_rd = 5'($urandom_range(0, 6)); m_reg_write = 1'($urandom); m_alu_result = $urandom;
      w_rd = 5'($urandom_range(0, 6)); w_reg_write = 1'($urandom); w_result = $urandom;
      #1;
      checks++;
      if (stall_d !== model_stall()) begin
        errors++;
        $display("FAIL rand_stall[%0d]: got %0b, expected %0b", i, stall_d, model_stall());
      end
      tick();
      checks++;
      if ({fwd_a, fwd_b, e_src_a, e_src_b, e_write_data} !==
          {model_fwd(cur.rs1), model_fwd(cur.rs2), model_opnd(model_fwd(cur.rs1), cur.rd1),
           (cur.ctrl.alu_src ? cur.imm : model_opnd(model_fwd(cur.rs2), cur.rd2)),
           model_opnd(model_fwd(cur.rs2), cur.rd2)}) begin
        errors++;
        $display("FAIL rand_fwd[%0d]: got fa=%0d fb=%0d a=%h b=%h wd=%h, expected fa=%0d fb=%0d",
                 i, fwd_a, fwd_b, e_src_a, e_src_b, e_write_data,
                 model_fwd(cur.rs1), model_fwd(cur.rs2));
      end
    end
    @(negedge clk);
    idle_inputs();
    tick();
  endtask

  task automatic test_double_hazard();
    @(negedge clk);
    idle_inputs();
    set_decode(1'b1, 5'd3, 5'd4, 5'd8, 32'h33, 32'h44, 32'h99, 32'h500,
               mk_ctrl(1'b1, RES_ALU, 1'b0, 1'b0));
    tick();
    @(negedge clk);
    idle_inputs();
    m_rd = 5'd3; m_reg_write = 1'b1; m_alu_result = 32'h11;
    w_rd = 5'd3; w_reg_write = 1'b1; w_result = 32'h22;
    #1;
    checks++;
    if ({fwd_a, e_src_a, fwd_b, e_src_b, e_write_data} !== {FWD_MEM, 32'h11, FWD_REG, 32'h44, 32'h44}) begin
      errors++;
      $display("FAIL double_mem: got fa=%0d a=%h fb=%0d b=%h wd=%h, expected fa=2 a=11 fb=0 b=44 wd=44",
               fwd_a, e_src_a, fwd_b, e_src_b, e_write_data);
    end
    m_reg_write = 1'b0;
    #1;
    checks++;
    if ({fwd_a, e_src_a} !== {FWD_WB, 32'h22}) begin
      errors++;
      $display("FAIL wb_only: got fa=%0d a=%h, expected fa=1 a=22", fwd_a, e_src_a);
    end
    m_rd = 5'd4; m_reg_write = 1'b1;
    #1;
    checks++;
    if ({fwd_a, e_src_a, fwd_b, e_src_b, e_write_data} !== {FWD_WB, 32'h22, FWD_MEM, 32'h11, 32'h11}) begin
      errors++;
      $display("FAIL split_fwd: got fa=%0d a=%h fb=%0d b=%h wd=%h, expected fa=1 a=22 fb=2 b=11 wd=11",
               fwd_a, e_src_a, fwd_b, e_src_b, e_write_data);
    end
    tick();
  endtask

  task automatic test_x0_writer();
    @(negedge clk);
    idle_inputs();
    set_decode(1'b1, 5'd0, 5'd0, 5'd1, 32'd0, 32'd0, 32'h7, 32'h600,
               mk_ctrl(1'b1, RES_ALU, 1'b0, 1'b0));
    tick();
    @(negedge clk);
    idle_inputs();
    m_rd = 5'd0; m_reg_write = 1'b1; m_alu_result = 32'hDEAD_BEEF;
    w_rd = 5'd0; w_reg_write = 1'b1; w_result = 32'hCAFE_F00D;
    #1;
    checks++;
    if ({fwd_a, e_src_a, fwd_b, e_write_data} !== {FWD_REG, 32'd0, FWD_REG, 32'd0}) begin
      errors++;
      $display("FAIL x0_writer: got fa=%0d a=%h fb=%0d wd=%h, expected fa=0 a=0 fb=0 wd=0",
               fwd_a, e_src_a, fwd_b, e_write_data);
    end
    tick();
  endtask

  task automatic test_load_use();
    @(negedge clk);
    idle_inputs();
    set_decode(1'b1, 5'd1, 5'd2, 5'd5, 32'h100, 32'h0, 32'h0, 32'h700,
               mk_ctrl(1'b1, RES_MEM, 1'b0, 1'b1));
    tick();
    @(negedge clk);
    set_decode(1'b1, 5'd5, 5'd7, 5'd6, 32'hAAAA_AAAA, 32'h77, 32'h0, 32'h704,
               mk_ctrl(1'b1, RES_ALU, 1'b0, 1'b0));
    #1;
    checks++;
    if (stall_d !== 1'b1) begin
      errors++;
      $display("FAIL load_use_stall: got %0b, expected 1", stall_d);
    end
    tick();
    @(negedge clk);
    m_rd = 5'd5; m_reg_write = 1'b1; m_alu_result = 32'h100;
    #1;
    checks++;
    if ({e_valid, stall_d} !== 2'b00) begin
      errors++;
      $display("FAIL load_use_bubble: got v=%0b stall=%0b, expected v=0 stall=0", e_valid, stall_d);
    end
    tick();
    @(negedge clk);
    d_valid = 1'b0; m_reg_write = 1'b0;
    w_rd = 5'd5; w_reg_write = 1'b1; w_result = 32'h5555;
    #1;
    checks++;
    if ({e_valid, e_rd, fwd_a, e_src_a, e_src_b} !== {1'b1, 5'd6, FWD_WB, 32'h5555, 32'h77}) begin
      errors++;
      $display("FAIL load_use_fwd: got v=%0b rd=%0d fa=%0d a=%h b=%h, expected v=1 rd=6 fa=1 a=5555 b=77",
               e_valid, e_rd, fwd_a, e_src_a, e_src_b);
    end
    tick();
    // Second load whose consumer only names x5 in rs2 (I-type): still stalls
    @(negedge clk);
    idle_inputs();
    set_decode(1'b1, 5'd1, 5'd2, 5'd5, 32'h200, 32'h0, 32'h4, 32'h800,
               mk_ctrl(1'b1, RES_MEM, 1'b0, 1'b1));
    tick();
    @(negedge clk);
    set_decode(1'b1, 5'd9, 5'd5, 5'd10, 32'h9, 32'h0, 32'h1, 32'h804,
               mk_ctrl(1'b1, RES_ALU, 1'b0, 1'b1));
    #1;
    checks++;
    if (stall_d !== 1'b1) begin
      errors++;
      $display("FAIL rs2_stall: got %0b, expected 1", stall_d);
    end
    tick();
    @(negedge clk);
    idle_inputs();
    tick();
  endtask

  task automatic test_flush();
    @(negedge clk);
    idle_inputs();
    set_decode(1'b1, 5'd1, 5'd2, 5'd5, 32'h300, 32'h0, 32'h0, 32'h900,
               mk_ctrl(1'b1, RES_MEM, 1'b0, 1'b1));
    tick();
    @(negedge clk);
    set_decode(1'b1, 5'd5, 5'd5, 5'd6, 32'h1, 32'h2, 32'h3, 32'h904,
               mk_ctrl(1'b1, RES_ALU, 1'b1, 1'b0));
    flush_e = 1'b1;
    #1;
    checks++;
    if (stall_d !== 1'b0) begin
      errors++;
      $display("FAIL flush_stall: got %0b, expected 0", stall_d);
    end
    tick();
    checks++;
    if ({e_valid, e_ctrl.reg_write, e_ctrl.mem_write} !== 3'b000) begin
      errors++;
      $display("FAIL flush_bubble: got v=%0b rw=%0b mw=%0b, expected 0 0 0",
               e_valid, e_ctrl.reg_write, e_ctrl.mem_write);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_dvalid_low();
    @(negedge clk);
    idle_inputs();
    set_decode(1'b0, 5'd2, 5'd3, 5'd4, 32'h12, 32'h34, 32'h56, 32'hA00,
               mk_ctrl(1'b1, RES_PC4, 1'b1, 1'b1));
    tick();
    checks++;
    if ({e_valid, e_ctrl} !== {1'b0, CTRL_NOP}) begin
      errors++;
      $display("FAIL dvalid_low: got v=%0b ctrl=%h, expected v=0 ctrl=%h", e_valid, e_ctrl, CTRL_NOP);
    end
  endtask

  task automatic test_reset_midstream();
    @(negedge clk);
    idle_inputs();
    set_decode(1'b1, 5'd1, 5'd2, 5'd5, 32'h1234, 32'h0, 32'h0, 32'hB00,
               mk_ctrl(1'b1, RES_MEM, 1'b0, 1'b1));
    tick();
    @(negedge clk);
    set_decode(1'b1, 5'd5, 5'd6, 5'd7, 32'h1, 32'h2, 32'h3, 32'hB04,
               mk_ctrl(1'b1, RES_ALU, 1'b0, 1'b0));
    #1;
    checks++;
    if ({e_valid, e_src_a, stall_d} !== {1'b1, 32'h1234, 1'b1}) begin
      errors++;
      $display("FAIL pre_reset: got v=%0b a=%h stall=%0b, expected v=1 a=1234 stall=1",
               e_valid, e_src_a, stall_d);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({e_valid, e_src_a, stall_d} !== {1'b0, 32'd0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: got v=%0b a=%h stall=%0b, expected v=0 a=0 stall=0",
               e_valid, e_src_a, stall_d);
    end
    #1 rst_n = 1'b1;
    sb.delete();
    cur = bubble_state();
    tick();
    @(negedge clk);
    idle_inputs();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_random_stream();
    test_double_hazard();
    test_x0_writer();
    test_load_use();
    test_flush();
    test_dvalid_low();
    test_reset_midstream();
    test_random_stream();
    #20;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter: XLEN, 32, datapath width.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: d_valid  input  1  decode stage holds a valid instruction.
REQ-005 Port: d_rs1, d_rs2, d_rd  input  5 each  decode register addresses.
REQ-006 Port: d_rd1, d_rd2  input  XLEN  register file read data.
REQ-007 Port: d_imm, d_pc  input  XLEN  immediate and PC of the decode instruction.
REQ-008 Port: d_ctrl  input  ctrl_t  decoded control bundle {reg_write, result_src, mem_write, branch, jump, alu_src, alu_ctrl}.
REQ-009 Port: flush_e  input  1  taken branch/jump resolved in EX; kills the decode instruction.
REQ-010 Port: m_rd  input  5; m_reg_write  input  1; m_alu_result  input  XLEN; MEM-stage writer.
REQ-011 Port: w_rd  input  5; w_reg_write  input  1; w_result  input  XLEN; WB-stage writer, identical to the register file write port.
REQ-012 Port: stall_d  output  1  freeze PC and IF/ID register.
REQ-013 Port: e_valid  output  1; e_rd  output  5; e_ctrl  output  ctrl_t; e_pc, e_imm  output  XLEN; registered EX fields.
REQ-014 Port: e_src_a, e_src_b, e_write_data  output  XLEN  forwarded ALU operands and store data.
REQ-015 Port: fwd_a, fwd_b  output  fwd_sel_t  forwarding selects.

Function
REQ-016 Latency SHALL be one cycle: fields captured on the rising clk edge.
REQ-017 Internal registers e_rs1, e_rs2, e_rd1, e_rd2 SHALL be captured alongside the outputs.
REQ-018 Capture SHALL load a bubble when flush_e=1, stall_d=1 or d_valid=0: e_valid=0, e_ctrl=CTRL_NOP, all address and data fields 0.
REQ-019 Otherwise capture SHALL load all d_* fields, with e_valid=1.
REQ-020 stall_d SHALL equal d_valid & e_valid & (e_ctrl.result_src==RES_MEM) & (e_rd!=0) & (e_rd==d_rs1 | e_rd==d_rs2) & ~flush_e.
REQ-021 Load-use matching on rs2 SHALL be unconditional, even for instructions that do not use rs2.
REQ-022 flush_e SHALL take priority over stall: stall_d=0 and a bubble is captured.
REQ-023 fwd_a SHALL be FWD_MEM if m_reg_write & m_rd!=0 & m_rd==e_rs1.
REQ-024 Else fwd_a SHALL be FWD_WB if w_reg_write & w_rd!=0 & w_rd==e_rs1; else FWD_REG. fwd_b SHALL follow the same rules using e_rs2.
REQ-025 MEM SHALL take priority over WB when both match.
REQ-026 fwd_a SHALL select e_src_a from m_alu_result, w_result or e_rd1; fwd_b SHALL select a forwarded rs2 value from m_alu_result, w_result or e_rd2.
REQ-027 e_write_data SHALL equal the forwarded rs2 value; e_src_b SHALL equal e_alu_src ? e_imm : the forwarded rs2 value.
REQ-028 No decode-stage bypass SHALL exist: the register file writes on the falling edge, so d_rd1/d_rd2 already reflect a same-cycle WB write.
REQ-029 Forwarding and stall logic SHALL be combinational; there SHALL be no path from d_rd1/d_rd2 to stall_d.

Reset
REQ-030 rst_n=0 SHALL immediately clear all registers to the bubble state of REQ-018, without waiting for clk.
REQ-031 During reset, stall_d SHALL be 0, fwd_a/fwd_b SHALL be FWD_REG, and e_src_a/e_src_b/e_write_data SHALL be 0.
REQ-032 Deassertion SHALL take effect at the first rising edge after rst_n=1.

Structure
REQ-033 riscv_pkg SHALL hold: ctrl_t struct; result_src_t {RES_ALU=0, RES_MEM=1, RES_PC4=2}; fwd_sel_t {FWD_REG=0, FWD_WB=1, FWD_MEM=2}; CTRL_NOP constant (all zeros).
REQ-034 The comparison and mux logic of REQ-023..027 SHALL be one sub-module, forward_unit, instantiated once.

Verification
REQ-035 Load-use: lw x5 in EX, add x6,x5,x7 in decode -> stall_d=1; next cycle e_valid=0; following cycle add is in EX with fwd_a=FWD_WB and e_src_a=w_result.
REQ-036 Double hazard: e_rs1=3, m_rd=3 and w_rd=3 with both reg_write=1, m_alu_result=0x11, w_result=0x22 -> fwd_a=FWD_MEM, e_src_a=0x11.
REQ-037 x0 writer: m_rd=0, m_reg_write=1, e_rs1=0, e_rd1=0 -> fwd_a=FWD_REG, e_src_a=0.
REQ-038 Flush during load-use condition -> stall_d=0; next cycle e_valid=0 and e_ctrl.reg_write=0, e_ctrl.mem_write=0.
REQ-039 rst_n pulsed low between clock edges mid-stream -> e_valid=0, e_src_a=0 and stall_d=0 before the next edge.
REQ-040 d_valid=0 with d_ctrl.reg_write=1 -> captured e_ctrl equals CTRL_NOP.
